// File: rtl/gabor_stream_conv_pkg.sv
// gabor_stream_conv_pkg: shared FSM state type, default Gabor kernel and clamp width constants
package gabor_stream_conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int GABOR_K = 5;
  localparam int MAX_KSIZE = 7;
  localparam int GUARD_W = $clog2(MAX_KSIZE * MAX_KSIZE);
  localparam logic [9:0] GABOR_COEF [25] = '{
    10'd0, 10'd238, 10'd22,  10'd238, 10'd0,
    10'd0, 10'd320, 10'd29,  10'd320, 10'd0,
    10'd0, 10'd353, 10'd512, 10'd353, 10'd0,
    10'd0, 10'd320, 10'd29,  10'd320, 10'd0,
    10'd0, 10'd238, 10'd22,  10'd238, 10'd0
  };
endpackage

// File: rtl/gabor_line_buf.sv
// gabor_line_buf: single-port shift RAM returning the value written DEPTH enabled cycles ago
module gabor_line_buf
  import gabor_stream_conv_pkg::*;
#(
  parameter int DEPTH = 132,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  assign dout = mem[ptr];
  // overwrite the oldest entry with the incoming pixel
  always_ff @(posedge clk)
    if (en) mem[ptr] <= din;
  // circular pointer; contents need no reset since every frame reloads them
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (en) ptr <= ptr == LAST ? '0 : ptr + AW'(1);
endmodule

// File: rtl/gabor_stream_conv.sv
// gabor_stream_conv: streaming KSIZE x KSIZE Gabor convolution with zero padding and saturation
module gabor_stream_conv
  import gabor_stream_conv_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int KSIZE  = 5,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 10,
  parameter int FRAC   = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             coef_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]                coef_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PIX_W-1:0]                 in_pixel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PIX_W-1:0]                 out_pixel,
  output logic                             busy,
  output logic                             frame_done
);
  localparam int NK = KSIZE * KSIZE;
  localparam int AW = $clog2(NK);
  localparam int LW = IMG_W + KSIZE - 1;
  localparam int LH = IMG_H + KSIZE - 1;
  localparam int CW = $clog2(LW);
  localparam int RW = $clog2(LH);
  localparam int OW = $clog2(IMG_W * IMG_H + 1);
  localparam int FW = PIX_W + COEF_W;
  localparam int SW = FW - FRAC + GUARD_W;
  localparam logic [SW-1:0] MAXV = SW'((1 << PIX_W) - 1);

  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [OW-1:0] out_cnt;
  logic scan_done, v_win, v_prod;
  logic stall, en, is_pix, scan_go, adv, complete, last_col, last_in, out_fire, last_out;
  logic [PIX_W-1:0] px;
  logic [COEF_W-1:0] coef [NK];
  logic [PIX_W-1:0] win [NK];
  logic [PIX_W-1:0] col_in [KSIZE];
  logic [PIX_W-1:0] lb_in [KSIZE-1];
  logic [PIX_W-1:0] lb_out [KSIZE-1];
  logic [FW-1:0] prod [NK];
  logic [SW-1:0] sum;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign is_pix   = row < RW'(IMG_H) && col < CW'(IMG_W);
  assign scan_go  = (state == RUN || state == FLUSH) && !scan_done;
  assign in_ready = state == RUN && scan_go && is_pix && en;
  assign adv      = scan_go && en && (!is_pix || in_valid);
  assign px       = is_pix ? in_pixel : '0;
  assign last_col = col == CW'(LW - 1);
  assign complete = row >= RW'(KSIZE - 1) && col >= CW'(KSIZE - 1);
  assign last_in  = in_valid && in_ready && row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1);
  assign out_fire = out_valid && out_ready;
  assign last_out = out_fire && out_cnt == OW'(IMG_W * IMG_H - 1);

  // window row m holds the scan row KSIZE-1-m rows back; the newest row comes straight from the stream
  assign col_in[KSIZE-1] = px;
  assign lb_in[0] = px;
  genvar i;
  for (i = 0; i < KSIZE - 1; i++) begin : g_lb
    assign col_in[i] = lb_out[KSIZE-2-i];
    gabor_line_buf #(.DEPTH(LW), .WIDTH(PIX_W)) u_lb (
      .clk(clk), .reset(reset), .en(adv), .din(lb_in[i]), .dout(lb_out[i])
    );
  end
  for (i = 1; i < KSIZE - 1; i++) begin : g_chain
    assign lb_in[i] = lb_out[i-1];
  end

  // frame sequencing, virtual scan position and output counting
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      scan_done <= 1'b0;
      out_cnt <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (adv) begin
        col <= last_col ? '0 : col + CW'(1);
        row <= row + RW'(last_col);
        scan_done <= last_col && row == RW'(LH - 1);
      end
      if (out_fire) out_cnt <= out_cnt + OW'(1);
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
          row <= '0;
          col <= '0;
          scan_done <= 1'b0;
          out_cnt <= '0;
        end
        RUN: if (last_in) state <= FLUSH;
        FLUSH: if (last_out) begin
          state <= DONE;
          frame_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end

  // kernel writes are accepted only between frames
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int k = 0; k < NK; k++) coef[k] <= '0;
    else if (state == IDLE && coef_we && coef_addr < AW'(NK)) coef[coef_addr] <= coef_data;

  // shift the window one column left and insert the new column on each scan advance
  always_ff @(posedge clk)
    if (adv)
      for (int m = 0; m < KSIZE; m++) begin
        for (int n = 0; n < KSIZE - 1; n++) win[m*KSIZE+n] <= win[m*KSIZE+n+1];
        win[m*KSIZE+KSIZE-1] <= col_in[m];
      end

  // stage 1: truncated fixed-point products
  always_ff @(posedge clk)
    if (en)
      for (int k = 0; k < NK; k++)
        prod[k] <= ({{COEF_W{1'b0}}, win[k]} * {{PIX_W{1'b0}}, coef[k]}) >> FRAC;

  // full-width sum of the truncated products, clamped only at the output
  always_comb begin
    sum = '0;
    for (int k = 0; k < NK; k++) sum = sum + SW'(prod[k]);
  end

  // valid tracking through both stages and the clamped result register, all frozen on stall
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v_win <= 1'b0;
      v_prod <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else if (en) begin
      v_win <= adv && complete;
      v_prod <= v_win;
      out_valid <= v_prod;
      if (v_prod) out_pixel <= sum > MAXV ? '1 : sum[PIX_W-1:0];
    end
endmodule

// File: tb/tb_gabor_stream_conv.sv
// tb_gabor_stream_conv: directed tests of the streaming Gabor convolution on 8x8 and 16x16 frames
module tb_gabor_stream_conv;
  import gabor_stream_conv_pkg::*;
  logic clk = 0, reset = 0, start8 = 0, start16 = 0, coef_we = 0, in_valid = 0, out_ready = 1;
  logic [4:0] coef_addr = '0;
  logic [9:0] coef_data = '0;
  logic [7:0] in_pixel = '0;
  logic ir8, ov8, busy8, fd8, ir16, ov16, busy16, fd16;
  logic [7:0] op8, op16;
  int checks = 0, errors = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  gabor_stream_conv #(.IMG_W(8), .IMG_H(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .in_valid(in_valid), .in_ready(ir8), .in_pixel(in_pixel),
    .out_valid(ov8), .out_ready(out_ready), .out_pixel(op8), .busy(busy8), .frame_done(fd8)
  );
  gabor_stream_conv #(.IMG_W(16), .IMG_H(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .in_valid(in_valid), .in_ready(ir16), .in_pixel(in_pixel),
    .out_valid(ov16), .out_ready(out_ready), .out_pixel(op16), .busy(busy16), .frame_done(fd16)
  );

  task automatic load_kernel(input bit gabor, input bit skip_center);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      coef_we = !(skip_center && i == 12);
      coef_addr = 5'(i);
      coef_data = gabor ? GABOR_COEF[i] : (i == 0 ? 10'd512 : 10'd0);
    end
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic run_frame(input bit big, input bit cst, input int val, input bit rnd,
                           input int abort_at, input bit start_wr, input int coef_pulse_at,
                           input int restart_at);
    int n = big ? 256 : 64;
    int idx = 0, cyc = 0, fd = 0, stalls = 0;
    bit prev_stall = 0, aborted = 0;
    logic ir, ov, bz, fdv;
    logic [7:0] op, held = 0;
    got.delete();
    @(negedge clk);
    if (big) start16 = 1; else start8 = 1;
    if (start_wr) begin
      coef_we = 1;
      coef_addr = 5'd12;
      coef_data = 10'd512;
    end
    @(negedge clk);
    start8 = 0;
    start16 = 0;
    coef_we = 0;
    while (fd == 0 && cyc < 20000) begin
      in_valid = idx < n;
      in_pixel = cst ? 8'(val) : 8'(idx);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_we = idx == coef_pulse_at;
      coef_addr = 5'd12;
      coef_data = 10'd1023;
      if (big) start16 = idx == restart_at; else start8 = idx == restart_at;
      #1;
      ir = big ? ir16 : ir8;
      ov = big ? ov16 : ov8;
      op = big ? op16 : op8;
      bz = big ? busy16 : busy8;
      fdv = big ? fd16 : fd8;
      if (cyc == 0) begin
        checks++;
        if (bz !== 1'b1) begin errors++; $display("FAIL busy_in_frame got %0b exp 1", bz); end
      end
      if (prev_stall) begin
        checks++;
        if (op !== held) begin errors++; $display("FAIL stall_hold got %0d exp %0d", op, held); end
      end
      prev_stall = ov && !out_ready;
      if (prev_stall) begin
        stalls++;
        held = op;
        checks++;
        if (ir !== 1'b0) begin errors++; $display("FAIL ready_in_stall got %0b exp 0", ir); end
      end
      if (in_valid && ir) idx++;
      if (ov && out_ready) begin
        got.push_back(op);
        if (abort_at > 0 && got.size() == abort_at) begin
          aborted = 1;
          break;
        end
      end
      if (fdv) fd++;
      @(negedge clk);
      cyc++;
    end
    coef_we = 0;
    start8 = 0;
    start16 = 0;
    if (aborted) begin
      int seen = 0;
      @(posedge clk);
      #1 reset = 0;
      in_valid = 0;
      #1;
      checks++;
      if ({ov8, busy8, ir8, ov16, busy16} !== 5'b0) begin
        errors++;
        $display("FAIL abort_clear got %b exp 00000", {ov8, busy8, ir8, ov16, busy16});
      end
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (10) begin
        @(negedge clk);
        #1 if (ov8 || ov16 || busy8 || busy16) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL abort_quiet got %0d exp 0", seen); end
    end else begin
      in_valid = 0;
      out_ready = 1;
      checks++;
      if (fd != 1) begin errors++; $display("FAIL frame_done_seen got %0d exp 1", fd); end
      @(negedge clk);
      #1;
      checks++;
      if ({busy8, fd8, busy16, fd16} !== 4'b0) begin
        errors++;
        $display("FAIL idle_after got %b exp 0000", {busy8, fd8, busy16, fd16});
      end
      if (rnd) begin
        checks++;
        if (stalls == 0) begin errors++; $display("FAIL stall_count got 0 exp >0"); end
      end
    end
  endtask

  task automatic test_reset;
    int nz = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ir8, ov8, busy8, fd8, op8} !== 12'b0) begin
      errors++;
      $display("FAIL reset8 got %h exp 000", {ir8, ov8, busy8, fd8, op8});
    end
    checks++;
    if ({ir16, ov16, busy16, fd16, op16} !== 12'b0) begin
      errors++;
      $display("FAIL reset16 got %h exp 000", {ir16, ov16, busy16, fd16, op16});
    end
    @(negedge clk);
    reset = 1;
    run_frame(0, 0, 0, 0, 0, 0, -1, -1);
    for (int i = 0; i < got.size(); i++) if (got[i] != 0) nz++;
    checks++;
    if (got.size() != 64) begin errors++; $display("FAIL zero_coef_count got %0d exp 64", got.size()); end
    checks++;
    if (nz != 0) begin errors++; $display("FAIL zero_coef_values got %0d nonzero exp 0", nz); end
  endtask

  task automatic test_identity;
    load_kernel(0, 0);
    run_frame(0, 0, 0, 0, 0, 0, -1, 10);
    checks++;
    if (got.size() != 64) begin errors++; $display("FAIL ident_count got %0d exp 64", got.size()); end
    if (got.size() == 64)
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got[i] !== 8'(i)) begin errors++; $display("FAIL ident_%0d got %0d exp %0d", i, got[i], i); end
      end
  endtask

  task automatic test_gabor_const(input int val, input int exp_in, input int exp_edge);
    load_kernel(1, 1);
    run_frame(1, 1, val, 0, 0, 1, -1, -1);
    checks++;
    if (got.size() != 256) begin errors++; $display("FAIL gabor_count got %0d exp 256", got.size()); end
    if (got.size() == 256) begin
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          checks++;
          if (got[r*16+c] != 8'(exp_in)) begin
            errors++;
            $display("FAIL gabor_%0d_%0d got %0d exp %0d", r, c, got[r*16+c], exp_in);
          end
        end
      checks++;
      if (got[12*16+12] != 8'(exp_edge)) begin
        errors++;
        $display("FAIL gabor_12_12 got %0d exp %0d", got[12*16+12], exp_edge);
      end
      checks++;
      if (got[255] != 8'd0) begin errors++; $display("FAIL gabor_15_15 got %0d exp 0", got[255]); end
    end
  endtask

  task automatic test_backpressure;
    load_kernel(0, 0);
    run_frame(0, 0, 0, 1, 0, 0, -1, -1);
    checks++;
    if (got.size() != 64) begin errors++; $display("FAIL bp_count got %0d exp 64", got.size()); end
    if (got.size() == 64)
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got[i] !== 8'(i)) begin errors++; $display("FAIL bp_%0d got %0d exp %0d", i, got[i], i); end
      end
  endtask

  task automatic test_reset_abort;
    load_kernel(0, 0);
    run_frame(0, 0, 0, 0, 20, 0, -1, -1);
    checks++;
    if (got.size() != 20) begin errors++; $display("FAIL abort_count got %0d exp 20", got.size()); end
    load_kernel(0, 0);
    run_frame(0, 0, 0, 0, 0, 0, -1, -1);
    checks++;
    if (got.size() != 64) begin errors++; $display("FAIL rerun_count got %0d exp 64", got.size()); end
    if (got.size() == 64)
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got[i] !== 8'(i)) begin errors++; $display("FAIL rerun_%0d got %0d exp %0d", i, got[i], i); end
      end
  endtask

  task automatic test_coef_locked;
    load_kernel(1, 0);
    run_frame(1, 1, 10, 0, 0, 0, 50, -1);
    checks++;
    if (got.size() != 256) begin errors++; $display("FAIL lock_count got %0d exp 256", got.size()); end
    if (got.size() == 256)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          checks++;
          if (got[r*16+c] != 8'd62) begin
            errors++;
            $display("FAIL lock_%0d_%0d got %0d exp 62", r, c, got[r*16+c]);
          end
        end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_gabor_const(10, 62, 54);
    test_gabor_const(100, 255, 255);
    test_backpressure;
    test_reset_abort;
    test_coef_locked;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
